// File: rtl/axis_fifo_if.sv
// AXI-Stream channel bundle: valid/ready handshake with data and end-of-packet marker.
// The master modport drives a stream and the slave modport consumes it.
interface axis_if #(
   parameter int DATA_W = 32
);
   logic              tvalid;
   logic              tready;
   logic [DATA_W-1:0] tdata;
   logic              tlast;

   modport master (output tvalid, output tdata, output tlast, input tready);
   modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/axis_fifo.sv
// First-word-fall-through AXI-Stream FIFO; a word pushed into an empty FIFO is visible one cycle later.
// Backpressure: s.tready drops at level==DEPTH and only recovers the cycle after a pop; m.tvalid tracks level!=0.
module axis_fifo #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 8
) (
   input  logic                   aclk,
   input  logic                   areset_n,
   axis_if.slave                  s,
   axis_if.master                 m,
   output logic [$clog2(DEPTH):0] level,
   output logic [$clog2(DEPTH):0] pkt_count
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

   logic [DATA_W:0]   mem_q [DEPTH];
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [AW:0]       level_q, level_d;
   logic [AW:0]       pkt_count_q, pkt_count_d;
   logic              ready_en_q, ready_en_d;
   logic              s_tready_c;
   logic              m_tvalid_c;
   logic              push;
   logic              pop;
   logic              pkt_in;
   logic              pkt_out;
   logic [DATA_W:0]   rd_word;

   // Readiness depends only on registered state, so a pop never frees a slot in the same cycle.
   always_comb begin
      s_tready_c  = ready_en_q && (level_q != FULL_LVL);
      m_tvalid_c  = (level_q != '0);
      rd_word     = mem_q[rd_ptr_q];
      push        = s.tvalid && s_tready_c;
      pop         = m_tvalid_c && m.tready;
      pkt_in      = push && s.tlast;
      pkt_out     = pop && rd_word[DATA_W];

      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      level_d     = level_q;
      pkt_count_d = pkt_count_q;
      ready_en_d  = 1'b1;

      if (push) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end

      unique case ({push, pop})
         2'b10:   level_d = level_q + (AW + 1)'(1);
         2'b01:   level_d = level_q - (AW + 1)'(1);
         default: level_d = level_q;
      endcase

      unique case ({pkt_in, pkt_out})
         2'b10:   pkt_count_d = pkt_count_q + (AW + 1)'(1);
         2'b01:   pkt_count_d = pkt_count_q - (AW + 1)'(1);
         default: pkt_count_d = pkt_count_q;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (!areset_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         pkt_count_q <= '0;
         ready_en_q  <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         pkt_count_q <= pkt_count_d;
         ready_en_q  <= ready_en_d;
      end
   end

   // Storage is left unreset; its output is only meaningful while m.tvalid is high.
   always_ff @(posedge aclk) begin
      if (areset_n && push) begin
         mem_q[wr_ptr_q] <= {s.tlast, s.tdata};
      end
   end

   assign s.tready  = s_tready_c;
   assign m.tvalid  = m_tvalid_c;
   assign m.tdata   = rd_word[DATA_W-1:0];
   assign m.tlast   = rd_word[DATA_W];
   assign level     = level_q;
   assign pkt_count = pkt_count_q;
endmodule
